// File: rtl/lc3_exec_unit.sv
// LC-3 operate-class execute/writeback stage: ADD, AND, NOT over a four-state
// READ/EXEC/WB sequence, with the NZP condition-code register updated on writeback.
module lc3_exec_unit #(
    parameter logic [2:0] CC_RESET = 3'b010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] ir,
    output logic [2:0]  rdAddrA,
    input  logic [15:0] rdDataA,
    output logic [2:0]  rdAddrB,
    input  logic [15:0] rdDataB,
    output logic        writeEN,
    output logic [2:0]  wrAddr,
    output logic [15:0] wrData,
    output logic [2:0]  nzp,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t             state, stateNext;
    logic [15:0]        irQ;
    logic signed [15:0] opA, opB;
    logic [15:0]        resQ;
    logic [2:0]         nzpQ;
    logic               illegalQ;
    logic               accept;

    function automatic logic isLegal(input logic [15:0] w);
        case (w[15:12])
            4'b0001, 4'b0101: return 1'b1;
            4'b1001:          return (w[5:0] == 6'b111111);
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic signed [15:0] sext5(input logic [4:0] imm);
        return {{11{imm[4]}}, imm};
    endfunction

    function automatic logic [2:0] condCode(input logic [15:0] v);
        if (v[15])
            return 3'b100;
        else if (v == 16'h0000)
            return 3'b010;
        else
            return 3'b001;
    endfunction

    assign accept = (state == IDLE) && start && isLegal(ir);

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = READ;
            READ:    stateNext = EXEC;
            EXEC:    stateNext = WB;
            WB:      stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            irQ      <= 16'h0000;
            opA      <= '0;
            opB      <= '0;
            resQ     <= 16'h0000;
            nzpQ     <= CC_RESET;
            illegalQ <= 1'b0;
        end else begin
            state    <= stateNext;
            illegalQ <= (state == IDLE) && start && !isLegal(ir);
            case (state)
                IDLE: if (accept) irQ <= ir;
                // operand capture; NOT simply never looks at opB
                READ: begin
                    opA <= rdDataA;
                    opB <= irQ[5] ? sext5(irQ[4:0]) : rdDataB;
                end
                EXEC: begin
                    case (irQ[15:12])
                        4'b0001: resQ <= opA + opB;
                        4'b0101: resQ <= opA & opB;
                        default: resQ <= ~opA;
                    endcase
                end
                WB:      nzpQ <= condCode(resQ);
                default: ;
            endcase
        end
    end

    assign rdAddrA = irQ[8:6];
    assign rdAddrB = irQ[2:0];
    assign wrAddr  = irQ[11:9];
    assign wrData  = resQ;
    assign writeEN = (state == WB);
    assign done    = (state == WB);
    assign busy    = (state != IDLE);
    assign nzp     = nzpQ;
    assign illegal = illegalQ;

endmodule

// File: tb/tb_lc3_exec_unit.sv
// Directed bench for lc3_exec_unit with a behavioural register file attached.
module tb_lc3_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] ir;
    logic [2:0]  rdAddrA, rdAddrB, wrAddr;
    logic [15:0] rdDataA, rdDataB, wrData;
    logic        writeEN, busy, done, illegal;
    logic [2:0]  nzp;

    logic [15:0] regs [8];
    int          wrCount = 0;
    int          nCompared = 0;
    int          nMismatched = 0;

    lc3_exec_unit #(.CC_RESET(3'b010)) dut (
        .clk(clk), .rst(rst), .start(start), .ir(ir),
        .rdAddrA(rdAddrA), .rdDataA(rdDataA),
        .rdAddrB(rdAddrB), .rdDataB(rdDataB),
        .writeEN(writeEN), .wrAddr(wrAddr), .wrData(wrData),
        .nzp(nzp), .busy(busy), .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign rdDataA = regs[rdAddrA];
    assign rdDataB = regs[rdAddrB];

    always @(posedge clk) begin
        if (writeEN) begin
            regs[wrAddr] <= wrData;
            wrCount      <= wrCount + 1;
        end
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction and follow it through READ, EXEC, WB and back to IDLE.
    task automatic runOp(input string tag, input logic [15:0] instr,
                         input logic injStart, input logic [15:0] injIr,
                         input logic [2:0] expAddr, input logic [15:0] expData,
                         input logic [2:0] expNzp);
        start = 1'b1;
        ir    = instr;
        tick();
        start = 1'b0;
        chk({tag, "/busyR"}, 16'(busy), 16'h1);
        chk({tag, "/sr1"}, 16'(rdAddrA), 16'(instr[8:6]));
        chk({tag, "/weR"}, 16'(writeEN), 16'h0);
        if (injStart) begin
            start = 1'b1;
            ir    = injIr;
        end
        tick();
        start = 1'b0;
        chk({tag, "/busyE"}, 16'(busy), 16'h1);
        tick();
        chk({tag, "/we"}, 16'(writeEN), 16'h1);
        chk({tag, "/done"}, 16'(done), 16'h1);
        chk({tag, "/wrAddr"}, 16'(wrAddr), 16'(expAddr));
        chk({tag, "/wrData"}, wrData, expData);
        chk({tag, "/illWB"}, 16'(illegal), 16'h0);
        tick();
        chk({tag, "/busyI"}, 16'(busy), 16'h0);
        chk({tag, "/weI"}, 16'(writeEN), 16'h0);
        chk({tag, "/nzp"}, 16'(nzp), 16'(expNzp));
        chk({tag, "/reg"}, regs[expAddr], expData);
    endtask

    task automatic rejectOp(input string tag, input logic [15:0] instr, input logic [2:0] expNzp);
        int wrBefore;
        wrBefore = wrCount;
        start = 1'b1;
        ir    = instr;
        tick();
        start = 1'b0;
        chk({tag, "/ill"}, 16'(illegal), 16'h1);
        chk({tag, "/busy"}, 16'(busy), 16'h0);
        chk({tag, "/we"}, 16'(writeEN), 16'h0);
        tick();
        chk({tag, "/illOff"}, 16'(illegal), 16'h0);
        chk({tag, "/busy2"}, 16'(busy), 16'h0);
        chk({tag, "/nzp"}, 16'(nzp), 16'(expNzp));
        chk({tag, "/writes"}, 16'(wrCount - wrBefore), 16'h0);
    endtask

    initial begin
        int wrBefore;
        for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
        rst   = 1'b1;
        start = 1'b0;
        ir    = 16'h0000;
        tick();
        tick();
        rst = 1'b0;
        chk("rst/busy", 16'(busy), 16'h0);
        chk("rst/we", 16'(writeEN), 16'h0);
        chk("rst/done", 16'(done), 16'h0);
        chk("rst/ill", 16'(illegal), 16'h0);
        chk("rst/nzp", 16'(nzp), 16'h2);
        chk("rst/wrData", wrData, 16'h0000);
        chk("rst/addrs", {7'd0, rdAddrA, rdAddrB, wrAddr}, 16'h0000);

        regs[1] = 16'h0005;
        regs[2] = 16'h0003;
        runOp("addReg", 16'h1642, 1'b0, 16'h0000, 3'd3, 16'h0008, 3'b001);

        regs[1] = 16'h0000;
        runOp("addImmNeg", 16'h187F, 1'b0, 16'h0000, 3'd4, 16'hFFFF, 3'b100);
        regs[1] = 16'h0001;
        runOp("addImmWrap", 16'h187F, 1'b0, 16'h0000, 3'd4, 16'h0000, 3'b010);

        regs[1] = 16'hF0F0;
        regs[2] = 16'h0FF0;
        runOp("and", 16'h5A42, 1'b0, 16'h0000, 3'd5, 16'h00F0, 3'b001);
        runOp("not", 16'h9C7F, 1'b0, 16'h0000, 3'd6, 16'h0F0F, 3'b001);

        rejectOp("illZero", 16'h0000, 3'b001);
        rejectOp("illNot", 16'h9C40, 3'b001);

        regs[1] = 16'h0007;
        runOp("busyIgn", 16'h1261, 1'b1, 16'h1642, 3'd1, 16'h0008, 3'b001);
        runOp("dep", 16'h1261, 1'b0, 16'h0000, 3'd1, 16'h0009, 3'b001);

        regs[1] = 16'h0005;
        regs[2] = 16'h0003;
        regs[3] = 16'h1234;
        wrBefore = wrCount;
        start = 1'b1;
        ir    = 16'h1642;
        tick();
        start = 1'b0;
        tick();
        chk("rstMid/busyE", 16'(busy), 16'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstMid/busy", 16'(busy), 16'h0);
        chk("rstMid/we", 16'(writeEN), 16'h0);
        chk("rstMid/nzp", 16'(nzp), 16'h2);
        tick();
        tick();
        chk("rstMid/writes", 16'(wrCount - wrBefore), 16'h0);
        chk("rstMid/reg", regs[3], 16'h1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/lc3_exec_unit.md
# lc3_exec_unit

Multi-cycle execute/writeback stage for the LC-3 datapath. It sits between the register file's read ports and its write port. It takes an operate-class instruction (ADD, AND, NOT), drives SR1/SR2 to the register file, captures Ra/Rb, computes the result, and writes it back on DR. It also maintains the NZP condition-code register consumed by branch logic.

## Interface
Parameters:
- CC_RESET, 3'b010, NZP value loaded on reset (Z set).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to execute `ir`; sampled only in IDLE.
- ir  in  16  instruction word, captured when `start` is accepted.
- rdAddrA  out  3  SR1 to register file = ir_q[8:6].
- rdDataA  in  16  Ra from register file (combinational read).
- rdAddrB  out  3  SR2 to register file = ir_q[2:0].
- rdDataB  in  16  Rb from register file.
- writeEN  out  1  register file write enable.
- wrAddr  out  3  DR = ir_q[11:9].
- wrData  out  16  writeback data (Buss).
- nzp  out  3  condition codes {N,Z,P}.
- busy  out  1  high in READ, EXEC, WB.
- done  out  1  one-cycle pulse, coincident with writeEN.
- illegal  out  1  one-cycle pulse, the cycle after an unsupported instruction is rejected.

## Operation
- Internal registers: ir_q, opA, opB, res_q, nzp, state.
- The FSM has four states: IDLE, READ, EXEC, WB.
- **IDLE:**
  - If `start` is high and ir[15:12] is 0001 (ADD) or 0101 (AND), capture `ir` into ir_q and go to READ.
  - If ir[15:12] is 1001 (NOT) with ir[5:0] = 6'b111111, do the same.
  - Any other `start`: do not capture, set `illegal` high next cycle, stay in IDLE.
- **READ:** capture opA ← rdDataA. Capture opB ← rdDataB if ir_q[5] = 0, else sext(ir_q[4:0]) to 16 bits. NOT ignores opB. Go to EXEC.
- **EXEC:** compute into res_q:
  - ADD: opA + opB, modulo 2^16, no carry out.
  - AND: opA & opB.
  - NOT: ~opA.
  - Go to WB.
- **WB:** writeEN = 1, wrAddr = ir_q[11:9], wrData = res_q, done = 1.
  - At the clock edge, load nzp: 100 if res_q[15]; 010 if res_q == 0; else 001.
  - nzp is always one-hot after the first writeback.
  - Go to IDLE.
- `start` is ignored while `busy` is high. No queuing.
- rdAddrA/rdAddrB are driven from ir_q in every state. In IDLE they hold the last instruction's values.
- Outside WB: writeEN = 0, done = 0, wrData = res_q, wrAddr = ir_q[11:9].
- Reset values:
  - state = IDLE, ir_q = 0, opA = opB = res_q = 0, nzp = CC_RESET.
  - Outputs: writeEN = done = busy = illegal = 0, rdAddrA = rdAddrB = wrAddr = 0, wrData = 0.

## Timing
- `start` accepted at edge 0 → READ during cycle 1, EXEC during cycle 2, WB during cycle 3.
- The register file write and the nzp update occur at the end of cycle 3. Next acceptance is possible in cycle 4.
- Issue rate is one instruction per 4 cycles.
- Back-to-back dependency (DR of instruction k = SR of instruction k+1) needs no bypass: READ of k+1 occurs at least 2 cycles after the WB edge of k.
- DR == SR1 within one instruction is legal: the operand is captured in READ, before the write.
- `rst` wins over every other event, including `start` in the same cycle.
- `rst` in READ/EXEC/WB: next cycle is IDLE. No write occurs, and nzp returns to CC_RESET.
- `rst` asserted during WB: the register file write still happens on that edge, because writeEN is combinational from state. The regfile's own reset clears it in the same edge, and reset takes priority there.
- `illegal` and `done` are never high in the same cycle.

## Test plan
- **ADD register:** R1 = 0x0005, R2 = 0x0003; ir = 0x1642 (ADD R3, R1, R2) → writeEN in cycle 3, wrAddr = 3, wrData = 0x0008, nzp = 001.
- **ADD imm negative with wrap:** R1 = 0x0000; ADD R4, R1, #-1 (ir = 0x187F) → wrData = 0xFFFF, nzp = 100. Then R1 = 0x0001 with the same imm → wrData = 0x0000, nzp = 010.
- **AND / NOT:**
  - R1 = 0xF0F0, R2 = 0x0FF0; AND R5, R1, R2 → 0x00F0, nzp = 001.
  - NOT R6, R1 (ir = 0x9C7F) → 0x0F0F.
- **Illegal:**
  - ir = 0x0000 with start → illegal pulse next cycle, busy stays 0, no writeEN, nzp unchanged.
  - ir = 0x9C40 (NOT with bad low bits) → same response.
- **start while busy and back-to-back dependency:**
  - Pulse start in cycle 1 with a different ir → ignored.
  - ADD R1, R1, #1 issued twice from R1 = 7 → second writeback = 9.
- **Reset mid-operation:** assert rst during EXEC → writeEN never asserts, busy = 0 next cycle, nzp = 010, target register unchanged.
